// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared constants and state encoding for the serial pattern
//                generator (seq_gen) and its shift-register helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Width of the repetition count and of the gap counter
    localparam int unsigned SEQ_CNT_W = 4;

    // Default transmitted pattern, MSB leaves first
    localparam logic [3:0] SEQ_PAT_0110 = 4'b0110;

    // Generator state encoding
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_IDLE = 2'd0;
    localparam seq_state_t ST_SEND = 2'd1;
    localparam seq_state_t ST_GAP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seq_gen_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_shreg
//  Description : Loadable MSB-first shift register. Load wins over shift.
//                o_msb is the bit currently at the head, o_nxt the bit that
//                reaches the head after the next shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen_shreg
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_pat,
    output logic             o_msb,
    output logic             o_nxt
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Next contents: parallel load, or shift towards the MSB with zero fill
    always_comb begin
        shreg_d = shreg_q;
        if (i_load) begin
            shreg_d = i_pat;
        end else if (i_shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register update with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign o_msb = shreg_q[WIDTH-1];
    assign o_nxt = shreg_q[WIDTH-2];

endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen
//  Description : Serial pattern generator. On an accepted start it shifts
//                PAT onto 'out' MSB first, count+1 times, with optional idle
//                gaps between repetitions and a graceful stop.
//                Build option: define SEQ_GEN_GAP_EN to insert GAP_CYC idle
//                cycles between repetitions; undefined runs them back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned      PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT      = PAT_W'(SEQ_PAT_0110),
    parameter logic             IDLE_BIT = 1'b1,
    parameter int unsigned      GAP_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEQ_CNT_W-1:0] count,
    input  logic                 stop,
    output logic                 ready,
    output logic                 out,
    output logic                 out_vld,
    output logic                 done
);

    localparam int unsigned          c_idx_w    = $clog2(PAT_W);
    localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(PAT_W - 1);
    localparam logic [c_idx_w-1:0]   c_pen_idx  = c_idx_w'(PAT_W - 2);

    seq_state_t           state_q,     state_d;
    logic [c_idx_w-1:0]   bit_idx_q,   bit_idx_d;
    logic [SEQ_CNT_W-1:0] rep_left_q,  rep_left_d;
    logic                 stop_seen_q, stop_seen_d;
    logic                 out_q,       out_d;
    logic                 out_vld_q,   out_vld_d;
    logic                 done_q,      done_d;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_sh_msb;
    logic                 w_sh_nxt;

`ifdef SEQ_GEN_GAP_EN
    localparam logic [SEQ_CNT_W-1:0] c_gap_last = SEQ_CNT_W'(GAP_CYC - 1);
    logic [SEQ_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
`else
    logic [SEQ_CNT_W-1:0] w_unused_gap;
    assign w_unused_gap = SEQ_CNT_W'(GAP_CYC);
`endif

    seq_gen_shreg #(
        .WIDTH   (PAT_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_pat   (PAT),
        .o_msb   (w_sh_msb),
        .o_nxt   (w_sh_nxt)
    );

    // FSM and counters; outputs are computed one cycle ahead so they register cleanly
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        rep_left_d  = rep_left_q;
        stop_seen_d = stop_seen_q;
        out_d       = IDLE_BIT;
        out_vld_d   = 1'b0;
        done_d      = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_cnt_d   = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SEND;
                    w_load      = 1'b1;
                    rep_left_d  = count;
                    bit_idx_d   = '0;
                    stop_seen_d = 1'b0;
                    out_d       = PAT[PAT_W-1];
                    out_vld_d   = 1'b1;
                end
            end
            ST_SEND: begin
                stop_seen_d = stop_seen_q | stop;
                if (bit_idx_q != c_last_idx) begin
                    w_shift   = 1'b1;
                    bit_idx_d = bit_idx_q + c_idx_w'(1);
                    out_d     = w_sh_nxt;
                    out_vld_d = 1'b1;
                    // done is registered, so the end-of-burst decision is taken
                    // on the edge that puts the final bit on the line
                    if (bit_idx_q == c_pen_idx) begin
                        done_d = (rep_left_q == '0) || stop_seen_q || stop;
                    end
                end else if ((rep_left_q == '0) || stop_seen_q) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = '0;
                end else begin
                    rep_left_d = rep_left_q - SEQ_CNT_W'(1);
                    w_load     = 1'b1;
                    bit_idx_d  = '0;
`ifdef SEQ_GEN_GAP_EN
                    state_d    = ST_GAP;
                    gap_cnt_d  = '0;
`else
                    out_d      = PAT[PAT_W-1];
                    out_vld_d  = 1'b1;
`endif
                end
            end
`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                stop_seen_d = stop_seen_q | stop;
                if (stop || stop_seen_q) begin
                    // abandon the remaining repetitions; done without a data bit
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == c_gap_last) begin
                    state_d   = ST_SEND;
                    out_d     = w_sh_msb;
                    out_vld_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + SEQ_CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            rep_left_q  <= '0;
            stop_seen_q <= 1'b0;
            out_q       <= IDLE_BIT;
            out_vld_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            rep_left_q  <= rep_left_d;
            stop_seen_q <= stop_seen_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            done_q      <= done_d;
`ifdef SEQ_GEN_GAP_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign out     = out_q;
    assign out_vld = out_vld_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_gen
//  Description : Self-checking bench for seq_gen. Expected line activity for
//                each burst is derived from pattern/repetition positions and
//                the stop rules, then compared cycle by cycle.
//                Follows the SEQ_GEN_GAP_EN build option of the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

    localparam int unsigned PAT_W    = 4;
    localparam logic [3:0]  C_PAT    = 4'b0110;
    localparam logic        IDLE_BIT = 1'b1;
    localparam int          GAP_CYC  = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] count;
    logic       stop;
    logic       ready;
    logic       out;
    logic       out_vld;
    logic       done;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic o;
        logic v;
        logic d;
        logic r;
    } exp_t;

    exp_t exp_q[$];

    seq_gen #(
        .PAT_W    (PAT_W),
        .PAT      (C_PAT),
        .IDLE_BIT (IDLE_BIT),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .stop     (stop),
        .ready    (ready),
        .out      (out),
        .out_vld  (out_vld),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, want);
        end
    endtask

    // Reference: expected (out, out_vld, done, ready) for cycles t+1.. of a burst
    // accepted at edge t. s = cycle (relative to t) during which stop is high.
    task automatic build_exp(input int c, input int s);
        int   pos;
        bit   stop_lat;
        bit   fin;
        logic pat;
        logic [3:0] pv;
        int   sg;
        exp_q.delete();
        pv       = C_PAT;
        pos      = 1;
        stop_lat = 1'b0;
        for (int r = 0; r <= c; r++) begin
            fin = (r == c) || stop_lat || (s >= pos && s <= pos + int'(PAT_W) - 2);
            for (int k = 0; k < int'(PAT_W); k++) begin
                pat = pv[int'(PAT_W) - 1 - k];
                exp_q.push_back('{o: pat, v: 1'b1, d: (fin && k == int'(PAT_W) - 1), r: 1'b0});
            end
            if (s == pos + int'(PAT_W) - 1) stop_lat = 1'b1;
            pos += int'(PAT_W);
            if (fin) return;
`ifdef SEQ_GEN_GAP_EN
            sg = stop_lat ? pos : s;
            if (sg >= pos && sg <= pos + GAP_CYC - 1) begin
                for (int g = pos; g <= sg; g++)
                    exp_q.push_back('{o: IDLE_BIT, v: 1'b0, d: 1'b0, r: 1'b0});
                exp_q.push_back('{o: IDLE_BIT, v: 1'b0, d: 1'b1, r: 1'b1});
                return;
            end
            for (int g = 0; g < GAP_CYC; g++)
                exp_q.push_back('{o: IDLE_BIT, v: 1'b0, d: 1'b0, r: 1'b0});
            pos += GAP_CYC;
`else
            sg = 0;
`endif
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_out"},  {31'd0, out},     {31'd0, IDLE_BIT});
        check_eq({tag, "_vld"},  {31'd0, out_vld}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done},    32'd0);
        check_eq({tag, "_rdy"},  {31'd0, ready},   32'd1);
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after the burst.
    task automatic run_burst(input int c, input int s, input bit hold,
                             input bit busy_start, output logic [63:0] obs);
        int n_done;
        build_exp(c, s);
        obs    = '0;
        n_done = 0;
        start  = 1'b1;
        count  = 4'(c);
        stop   = (s == 0);
        @(posedge clk);
        for (int j = 1; j <= exp_q.size(); j++) begin
            @(negedge clk);
            check_eq("out",  {31'd0, out},     {31'd0, exp_q[j-1].o});
            check_eq("vld",  {31'd0, out_vld}, {31'd0, exp_q[j-1].v});
            check_eq("done", {31'd0, done},    {31'd0, exp_q[j-1].d});
            check_eq("rdy",  {31'd0, ready},   {31'd0, exp_q[j-1].r});
            obs = {obs[62:0], out};
            if (done) n_done++;
            start = hold ? 1'b1 : (busy_start && !exp_q[j-1].r && ($urandom_range(0, 2) == 0));
            count = 4'($urandom);
            stop  = (j == s);
        end
        @(negedge clk);
        check_idle("post");
        if (done) n_done++;
        check_eq("done_pulses", n_done, 32'd1);
        stop  = 1'b0;
        start = hold;
    endtask

    // Reset asserted while the 3rd bit is on the line aborts the burst
    task automatic rst_mid();
        logic [3:0] pv;
        pv    = C_PAT;
        start = 1'b1;
        count = 4'd5;
        stop  = 1'b0;
        @(posedge clk);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check_eq("rst_bit", {31'd0, out}, {31'd0, pv[int'(PAT_W) - j]});
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("rstmid");
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_idle("rstafter");
        end
    endtask

    initial begin
        logic [63:0] obs;
        int          c;
        int          s;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        count    = 4'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        // Single pattern, count=0
        run_burst(0, -1, 1'b0, 1'b0, obs);
        check_eq("single_pat", {28'd0, obs[3:0]}, 32'h6);

`ifdef SEQ_GEN_GAP_EN
        // count=2 with two idle bits between repetitions
        run_burst(2, -1, 1'b0, 1'b0, obs);
        check_eq("gap_seq", {16'd0, obs[15:0]}, 32'h6DB6);
        // stop landing in the first gap cycle
        run_burst(3, int'(PAT_W) + 1, 1'b0, 1'b0, obs);
`else
        // count=1 runs back-to-back
        run_burst(1, -1, 1'b0, 1'b0, obs);
        check_eq("b2b_seq", {24'd0, obs[7:0]}, 32'h66);
`endif

        // count=3, stop on the 2nd bit of the first repetition
        run_burst(3, 2, 1'b0, 1'b0, obs);
        check_eq("stop_seq", {28'd0, obs[3:0]}, 32'h6);

        // stop together with the accepting start is ignored
        run_burst(1, 0, 1'b0, 1'b0, obs);

        rst_mid();

        // start held high: ignored while busy, re-accepted when ready rises
        run_burst(0, -1, 1'b1, 1'b0, obs);
        run_burst(0, -1, 1'b0, 1'b0, obs);

        // Randomized bursts with stray start/stop activity
        for (int n = 0; n < 40; n++) begin
            c = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) s = -1;
            else s = int'($urandom_range(0, (c + 1) * (int'(PAT_W) + GAP_CYC)));
            run_burst(c, s, 1'b0, 1'b1, obs);
            for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
                stop = 1'($urandom);
                @(negedge clk);
                check_idle("gapidle");
            end
            stop = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator: on a start handshake it shifts a fixed PAT_W-bit pattern (default 0110) onto a single-bit line, MSB first, repeating it a programmable number of times. It is the transmit-side counterpart of the team's serial sequence detectors. Benches and on-chip self-test use it to drive a detector's serial input.

## Interface
Parameters:
- PAT_W, 4: pattern length in bits (2..16).
- PAT, 4'b0110: pattern; bit PAT_W-1 is transmitted first.
- IDLE_BIT, 1'b1: line level whenever no pattern bit is being driven.
- GAP_CYC, 2: idle-bit cycles between repetitions (used only with gap insertion compiled in; 1..15).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a burst; accepted only when ready=1.
- count  in  4  repetitions minus one; sampled on accept (0 means 1 rep, 15 means 16 reps).
- stop  in  1  graceful stop: finish the current pattern, then end the burst.
- ready  out  1  high in IDLE; decoded from state.
- out  out  1  serial line, registered.
- out_vld  out  1  high while out carries a pattern bit, registered.
- done  out  1  one-cycle end-of-burst pulse, registered.

## Operation
- FSM states: IDLE, SEND, GAP. Reset state is IDLE.
- IDLE to SEND on start and ready. The accept edge loads the shift register with PAT, loads rep_left with count, clears bit_idx and clears stop_seen.
- SEND drives one bit per cycle. After bit PAT_W-1:
  - if rep_left is 0 or stop_seen is set, go to IDLE and pulse done;
  - otherwise decrement rep_left, reload PAT, and go to GAP (gap compiled in) or stay in SEND (gap compiled out).
- GAP drives IDLE_BIT with out_vld=0 for GAP_CYC cycles, then returns to SEND.
- stop is OR-ed into sticky stop_seen during SEND and GAP.
  - In SEND: the current pattern always completes.
  - In GAP: the FSM goes to IDLE at the next edge and pulses done in that cycle. No further pattern bits are sent.
- start while not ready is ignored; it is not queued. stop in IDLE is ignored.
- Reset values: out=IDLE_BIT, out_vld=0, done=0, ready=1, all counters 0.
- Reset asserted mid-burst aborts it: the next edge gives IDLE outputs with no done pulse. The partial pattern is not completed.
- Widths: bit_idx is clog2(PAT_W) bits, rep_left is 4 bits, the gap counter is 4 bits. No counter wraps; each is bounded by a state exit.

## Timing
- Start accepted at edge t: first bit (PAT[PAT_W-1]) on out from cycle t+1, with out_vld=1.
- One bit per cycle. A burst without gaps occupies (count+1)*PAT_W cycles.
- done is high in the cycle carrying the final bit, coincident with out_vld. Exception: a stop that lands in GAP pulses done with out_vld=0.
- ready rises the cycle after the final bit. The earliest re-start is accepted in that cycle, with its first bit one cycle later. The minimum inter-burst gap is one idle cycle.
- stop must be high at an edge during SEND/GAP to be seen. A stop in the same cycle as the accepting start is ignored.

## Configuration
- SEQ_GEN_GAP_EN defined: GAP state and gap counter are present; GAP_CYC idle bits separate repetitions. A burst then lasts (count+1)*PAT_W + count*GAP_CYC cycles.
- SEQ_GEN_GAP_EN undefined: GAP state and counter are removed, repetitions run back-to-back, and GAP_CYC is unused.

## Structure
- Shared package seq_pkg holds:
  - the state typedef (IDLE/SEND/GAP);
  - the default pattern constant SEQ_PAT_0110;
  - the count width constant (4).
- One sub-module, seq_gen_shreg: a loadable PAT_W-bit MSB-first shift register with load/shift enables. The top holds the FSM and counters.

## Test plan
- Reset, then start with count=0: out=0,1,1,0 on cycles t+1..t+4 with out_vld=1, done at t+4, ready=1 at t+5, out=1 after.
- Gap defined, GAP_CYC=2, count=2: out=0110 11 0110 11 0110 over 16 cycles; out_vld low on gap bits; a single done on the last 0.
- Gap undefined, count=1: out=01100110 over 8 contiguous cycles with out_vld=1 throughout, and done on cycle 8.
- count=3, stop pulsed on the 2nd bit of rep 1: only one pattern is sent and done comes on its last bit. Separately, with gap defined, stop in GAP: done with out_vld=0 at the next cycle.
- rst asserted while the 3rd bit is driven: next cycle out=1, out_vld=0, ready=1, and done never pulses.
- start held high through a whole count=0 burst: ignored while busy, re-accepted the cycle ready rises, and the second burst's first bit appears one cycle later.
